// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Mealy control outputs, small RUN/FLUSH/MC_WAIT FSM, saturating counters.
module pipe_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned MC_TIMEOUT   = 64,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_jb_taken,
   input  logic             mc_start,
   input  logic             mc_done,
   input  logic             clr_cnt,
   output logic             pc_en,
   output logic             fd_en,
   output logic             fd_flush,
   output logic             de_bubble,
   output logic             de_hold,
   output logic             em_bubble,
   output logic [1:0]       state_o,
   output logic             mc_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_FLUSH = 2'd1,
      S_MCW   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       rem_q, rem_d;
   logic [7:0]       wait_q, wait_d;
   logic             tmo_q, tmo_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             jb_evt;
   logic             load_use;

   assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   // Next state and Mealy control outputs; reset forces a safe pipeline clear.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      wait_d    = wait_q;
      tmo_d     = tmo_q;
      jb_evt    = 1'b0;
      pc_en     = 1'b1;
      fd_en     = 1'b1;
      fd_flush  = 1'b0;
      de_bubble = 1'b0;
      de_hold   = 1'b0;
      em_bubble = 1'b0;
      unique case (state_q)
         S_RUN: begin
            if (ex_jb_taken) begin
               fd_flush  = 1'b1;
               de_bubble = 1'b1;
               jb_evt    = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d = S_FLUSH;
                  rem_d   = 3'(FLUSH_CYCLES - 1);
               end
            end else if (mc_start) begin
               pc_en     = 1'b0;
               fd_en     = 1'b0;
               de_hold   = 1'b1;
               em_bubble = 1'b1;
               state_d   = S_MCW;
               wait_d    = 8'd1;
            end else if (load_use) begin
               pc_en     = 1'b0;
               fd_en     = 1'b0;
               de_bubble = 1'b1;
            end
         end
         S_FLUSH: begin
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
            if (rem_q <= 3'd1) begin
               state_d = S_RUN;
               rem_d   = 3'd0;
            end else begin
               rem_d = rem_q - 3'd1;
            end
         end
         S_MCW: begin
            if (mc_done) begin
               state_d = S_RUN;
               wait_d  = 8'd0;
            end else if (wait_q >= 8'(MC_TIMEOUT)) begin
               tmo_d   = 1'b1;
               state_d = S_RUN;
               wait_d  = 8'd0;
            end else begin
               pc_en     = 1'b0;
               fd_en     = 1'b0;
               de_hold   = 1'b1;
               em_bubble = 1'b1;
               wait_d    = wait_q + 8'd1;
            end
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
      if (!rst_n) begin
         pc_en     = 1'b0;
         fd_en     = 1'b0;
         fd_flush  = 1'b1;
         de_bubble = 1'b1;
         de_hold   = 1'b0;
         em_bubble = 1'b1;
      end
   end

   // Saturating counters; a clear beats any increment in the same cycle.
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (clr_cnt) begin
         stall_d = '0;
         flush_d = '0;
      end else begin
         if (!pc_en && (stall_q != '1)) stall_d = stall_q + 1'b1;
         if (jb_evt && (flush_q != '1)) flush_d = flush_q + 1'b1;
      end
   end

   // State, window counters, sticky timeout and performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_RUN;
         rem_q   <= 3'd0;
         wait_q  <= 8'd0;
         tmo_q   <= 1'b0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         wait_q  <= wait_d;
         tmo_q   <= tmo_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign state_o    = state_q;
   assign mc_timeout = tmo_q;
   assign stall_cnt  = stall_q;
   assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scenario bench for pipe_hazard_ctrl.
// Expected per-cycle records are queued with the stimulus, popped at negedge.
module tb_pipe_hazard_ctrl;

   localparam logic [5:0] C_RUN = 6'b110000;
   localparam logic [5:0] C_JB  = 6'b111100;
   localparam logic [5:0] C_MC  = 6'b000011;
   localparam logic [5:0] C_LU  = 6'b000100;
   localparam logic [5:0] C_RST = 6'b001101;

   localparam logic [6:0] F_U1  = 7'b1000000;
   localparam logic [6:0] F_U2  = 7'b0100000;
   localparam logic [6:0] F_LD  = 7'b0010000;
   localparam logic [6:0] F_JB  = 7'b0001000;
   localparam logic [6:0] F_MS  = 7'b0000100;
   localparam logic [6:0] F_MD  = 7'b0000010;
   localparam logic [6:0] F_CLR = 7'b0000001;
   localparam logic [6:0] F_0   = 7'b0000000;

   typedef struct packed {
      logic [5:0] ctl;
      logic [1:0] st;
      logic [3:0] sc;
      logic [3:0] fc;
      logic       to;
   } exp_t;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic [6:0] f;
      exp_t       e;
   } stim_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0;
   logic       ex_jb_taken = 0, mc_start = 0, mc_done = 0, clr_cnt = 0;
   logic       pc_en, fd_en, fd_flush, de_bubble, de_hold, em_bubble;
   logic [1:0] state_o;
   logic       mc_timeout;
   logic [3:0] stall_cnt, flush_cnt;

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb[$];

   pipe_hazard_ctrl #(
      .FLUSH_CYCLES(2),
      .MC_TIMEOUT  (8),
      .CNT_W       (4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load),
      .ex_jb_taken(ex_jb_taken), .mc_start(mc_start),
      .mc_done(mc_done), .clr_cnt(clr_cnt),
      .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush),
      .de_bubble(de_bubble), .de_hold(de_hold),
      .em_bubble(em_bubble), .state_o(state_o),
      .mc_timeout(mc_timeout),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic stim_t r(input logic [4:0] rs1,
                               input logic [4:0] rs2,
                               input logic [4:0] rd,
                               input logic [6:0] f,
                               input logic [5:0] ctl,
                               input logic [1:0] st,
                               input logic [3:0] sc,
                               input logic [3:0] fc,
                               input logic       to);
      stim_t s;
      s.rs1 = rs1; s.rs2 = rs2; s.rd = rd; s.f = f;
      s.e.ctl = ctl; s.e.st = st; s.e.sc = sc;
      s.e.fc = fc; s.e.to = to;
      return s;
   endfunction

   function automatic exp_t obs();
      exp_t o;
      o.ctl = {pc_en, fd_en, fd_flush, de_bubble, de_hold, em_bubble};
      o.st = state_o; o.sc = stall_cnt;
      o.fc = flush_cnt; o.to = mc_timeout;
      return o;
   endfunction

   task automatic apply(input stim_t s);
      id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
      {id_use_rs1, id_use_rs2, ex_is_load, ex_jb_taken,
       mc_start, mc_done, clr_cnt} = s.f;
   endtask

   task automatic test_reset();
      exp_t e, o;
      rst_n = 1'b0;
      apply(r(0, 0, 0, F_0, C_RST, 0, 0, 0, 0));
      sb.push_back('{C_RST, 2'd0, 4'd0, 4'd0, 1'b0});
      @(negedge clk);
      e = sb.pop_front(); o = obs(); n_chk++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL reset_hold got %b want %b", o, e);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.push_back('{C_RUN, 2'd0, 4'd0, 4'd0, 1'b0});
      @(negedge clk);
      e = sb.pop_front(); o = obs(); n_chk++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL reset_release got %b want %b", o, e);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_load_use();
      stim_t t[$];
      exp_t  e, o;
      t.push_back(r(0, 5, 5, F_LD|F_U2, C_LU, 0, 0, 0, 0));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 1, 0, 0));
      t.push_back(r(0, 0, 0, F_LD|F_U1|F_U2, C_RUN, 0, 1, 0, 0));
      t.push_back(r(7, 0, 7, F_LD|F_U1, C_LU, 0, 1, 0, 0));
      t.push_back(r(7, 3, 7, F_LD|F_U2, C_RUN, 0, 2, 0, 0));
      t.push_back(r(7, 0, 7, F_U1, C_RUN, 0, 2, 0, 0));
      t.push_back(r(0, 0, 0, F_CLR, C_RUN, 0, 2, 0, 0));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 0, 0, 0));
      foreach (t[i]) begin
         apply(t[i]); sb.push_back(t[i].e);
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL load_use[%0d] got %b want %b", i, o, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      stim_t t[$];
      exp_t  e, o;
      t.push_back(r(0, 0, 0, F_JB, C_JB, 0, 0, 0, 0));
      t.push_back(r(0, 5, 5, F_LD|F_U2|F_MS, C_JB, 1, 0, 1, 0));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 0, 1, 0));
      t.push_back(r(0, 0, 0, F_JB, C_JB, 0, 0, 1, 0));
      t.push_back(r(0, 0, 0, F_JB, C_JB, 1, 0, 2, 0));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 0, 2, 0));
      t.push_back(r(0, 0, 0, F_CLR, C_RUN, 0, 0, 2, 0));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 0, 0, 0));
      foreach (t[i]) begin
         apply(t[i]); sb.push_back(t[i].e);
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL branch[%0d] got %b want %b", i, o, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_multicycle();
      stim_t t[$];
      exp_t  e, o;
      t.push_back(r(0, 0, 0, F_MS, C_MC, 0, 0, 0, 0));
      t.push_back(r(0, 0, 0, F_0, C_MC, 2, 1, 0, 0));
      t.push_back(r(0, 5, 5, F_JB|F_LD|F_U2, C_MC, 2, 2, 0, 0));
      t.push_back(r(0, 0, 0, F_0, C_MC, 2, 3, 0, 0));
      t.push_back(r(0, 0, 0, F_0, C_MC, 2, 4, 0, 0));
      t.push_back(r(0, 0, 0, F_0, C_MC, 2, 5, 0, 0));
      t.push_back(r(0, 0, 0, F_MD, C_RUN, 2, 6, 0, 0));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 6, 0, 0));
      t.push_back(r(0, 0, 0, F_MD, C_RUN, 0, 6, 0, 0));
      t.push_back(r(0, 0, 0, F_CLR, C_RUN, 0, 6, 0, 0));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 0, 0, 0));
      foreach (t[i]) begin
         apply(t[i]); sb.push_back(t[i].e);
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL multicycle[%0d] got %b want %b", i, o, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_priority();
      stim_t t[$];
      exp_t  e, o;
      t.push_back(r(5, 0, 5, F_JB|F_MS|F_LD|F_U1, C_JB, 0, 0, 0, 0));
      t.push_back(r(0, 0, 0, F_0, C_JB, 1, 0, 1, 0));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 0, 1, 0));
      t.push_back(r(5, 0, 5, F_MS|F_LD|F_U1, C_MC, 0, 0, 1, 0));
      t.push_back(r(0, 0, 0, F_MD, C_RUN, 2, 1, 1, 0));
      t.push_back(r(0, 0, 0, F_CLR, C_RUN, 0, 1, 1, 0));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 0, 0, 0));
      foreach (t[i]) begin
         apply(t[i]); sb.push_back(t[i].e);
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL priority[%0d] got %b want %b", i, o, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      stim_t t[$];
      exp_t  e, o;
      t.push_back(r(0, 0, 0, F_MS, C_MC, 0, 0, 0, 0));
      for (int k = 1; k < 8; k++)
         t.push_back(r(0, 0, 0, F_0, C_MC, 2, 4'(k), 0, 0));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 2, 8, 0, 0));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 8, 0, 1));
      t.push_back(r(0, 0, 0, F_MS, C_MC, 0, 8, 0, 1));
      t.push_back(r(0, 0, 0, F_MD, C_RUN, 2, 9, 0, 1));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 9, 0, 1));
      foreach (t[i]) begin
         apply(t[i]); sb.push_back(t[i].e);
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL timeout[%0d] got %b want %b", i, o, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid_mc();
      stim_t t[$];
      exp_t  e, o;
      t.push_back(r(0, 0, 0, F_MS, C_MC, 0, 9, 0, 1));
      t.push_back(r(0, 0, 0, F_0, C_MC, 2, 10, 0, 1));
      foreach (t[i]) begin
         apply(t[i]); sb.push_back(t[i].e);
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid_mc[%0d] got %b want %b", i, o, e);
         end
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      sb.push_back('{C_RST, 2'd0, 4'd0, 4'd0, 1'b0});
      #1;
      e = sb.pop_front(); o = obs(); n_chk++;
      if (o !== e) begin
         n_fail++;
         $display("FAIL reset_async got %b want %b", o, e);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      t.delete();
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 0, 0, 0));
      t.push_back(r(0, 0, 0, F_MD, C_RUN, 0, 0, 0, 0));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 0, 0, 0));
      foreach (t[i]) begin
         apply(t[i]); sb.push_back(t[i].e);
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_after[%0d] got %b want %b", i, o, e);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_saturate_clr();
      stim_t t[$];
      exp_t  e, o;
      for (int k = 0; k < 18; k++)
         t.push_back(r(0, 5, 5, F_LD|F_U2, C_LU, 0,
                       (k > 15) ? 4'd15 : 4'(k), 0, 0));
      t.push_back(r(0, 5, 5, F_LD|F_U2|F_CLR, C_LU, 0, 15, 0, 0));
      t.push_back(r(0, 0, 0, F_0, C_RUN, 0, 0, 0, 0));
      foreach (t[i]) begin
         apply(t[i]); sb.push_back(t[i].e);
         @(negedge clk);
         e = sb.pop_front(); o = obs(); n_chk++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL saturate_clr[%0d] got %b want %b", i, o, e);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_multicycle();
      test_priority();
      test_timeout();
      test_reset_mid_mc();
      test_saturate_clr();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It takes decode-stage register usage, execute-stage load, branch and multi-cycle status, and generates the PC enable, IF/ID enable/flush, ID/EX bubble/hold and EX/MEM bubble controls. A small FSM handles branch-flush windows and multi-cycle unit waits. Performance counters record stall and flush activity.

Parameters:
FLUSH_CYCLES, 1, total cycles of IF/ID + ID/EX flush per taken branch/jump (range 1..4)
MC_TIMEOUT, 64, max MC_WAIT cycles before forced exit (range 2..255)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  5  decode-stage rs1 index
id_rs2  in  5  decode-stage rs2 index
id_use_rs1  in  1  decode instruction reads rs1
id_use_rs2  in  1  decode instruction reads rs2
ex_rd  in  5  execute-stage destination index
ex_is_load  in  1  execute-stage instruction is a load
ex_jb_taken  in  1  execute-stage branch taken or jump
mc_start  in  1  execute-stage multi-cycle op (mul/div) launched this cycle
mc_done  in  1  multi-cycle unit result valid (one-cycle pulse)
clr_cnt  in  1  synchronous clear of both counters
pc_en  out  1  PC register load enable
fd_en  out  1  IF/ID load enable
fd_flush  out  1  IF/ID clear
de_bubble  out  1  ID/EX clear (insert NOP)
de_hold  out  1  ID/EX hold current contents
em_bubble  out  1  EX/MEM clear
state_o  out  2  FSM state (0 RUN, 1 FLUSH, 2 MC_WAIT)
mc_timeout  out  1  sticky: MC_WAIT exited by timeout
stall_cnt  out  CNT_W  cycles with pc_en=0 outside reset, saturating
flush_cnt  out  CNT_W  taken-branch flush events, saturating

Behaviour:
- Control outputs are Mealy (state + current inputs), no added latency. Counters, state and mc_timeout are registered.
- rst_n low (async): state=RUN, flush counter=0, wait counter=0, mc_timeout=0, stall_cnt=flush_cnt=0. While rst_n low, outputs are forced to pc_en=0, fd_en=0, fd_flush=1, de_bubble=1, de_hold=0, em_bubble=1. Reset release mid-FLUSH or mid-MC_WAIT returns to RUN with no residual flush or wait.
- Default (RUN, no event): pc_en=1, fd_en=1, all flush/bubble/hold=0.
- RUN priority, highest first:
  1. ex_jb_taken=1: pc_en=1, fd_flush=1, de_bubble=1. flush_cnt+1. If FLUSH_CYCLES>1, go to FLUSH with remaining=FLUSH_CYCLES-1. Otherwise stay in RUN.
  2. mc_start=1: pc_en=0, fd_en=0, de_hold=1, em_bubble=1. Go to MC_WAIT with wait counter=1.
  3. Load-use: ex_is_load and ex_rd!=0 and ((id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd)). Then pc_en=0, fd_en=0, de_bubble=1 for this cycle only. Stay in RUN; the hazard clears when the load leaves EX.
  - ex_rd==0 never causes a load-use stall.
- FLUSH:
  - Outputs: pc_en=1, fd_flush=1, de_bubble=1.
  - remaining decrements each cycle; return to RUN in the cycle after remaining reaches 1.
  - All hazard and mc inputs are ignored.
- MC_WAIT:
  - Outputs: pc_en=0, fd_en=0, de_hold=1, em_bubble=1. ex_jb_taken and load-use are ignored.
  - mc_done=1: in that same cycle, outputs take the RUN defaults (pc_en=1, fd_en=1, de_hold=0, em_bubble=0). Next state is RUN.
  - Otherwise the wait counter increments. When it equals MC_TIMEOUT without mc_done: set mc_timeout, release as for mc_done, go to RUN.
  - mc_timeout clears only on reset.
- mc_done arriving in RUN or FLUSH is ignored.
- Counters:
  - stall_cnt increments on any cycle with rst_n high and pc_en=0.
  - Both counters saturate at all-ones.
  - clr_cnt has priority over increment in the same cycle.
- ex_jb_taken and mc_start asserted together in RUN: the branch wins and mc_start is dropped.

Test Plan:
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> that cycle pc_en=0, fd_en=0, de_bubble=1; next cycle (ex_is_load=0) defaults; stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Branch, FLUSH_CYCLES=2: ex_jb_taken pulse -> fd_flush=de_bubble=1 for 2 consecutive cycles, pc_en=1 throughout, state_o 0->1->0, flush_cnt=1.
- Multi-cycle: mc_start, then mc_done 6 cycles later -> pc_en=0, de_hold=1, em_bubble=1 for 6 cycles; in the mc_done cycle pc_en=1, de_hold=0; stall_cnt=6.
- Timeout, MC_TIMEOUT=4: mc_start, no mc_done -> exit to RUN after 4 stall cycles, mc_timeout=1 and stays 1.
- Priority: ex_jb_taken=mc_start=1 with a load-use match -> flush outputs only, state never MC_WAIT. A load-use match during MC_WAIT -> no de_bubble.
- Reset mid-MC_WAIT: drop rst_n -> immediately state_o=0, counters 0, forced reset outputs; after release, RUN defaults. clr_cnt with stall_cnt at all-ones -> 0.
